riscv_writeback_unit: RTL and testbench

- Final stage of the multicycle RISC-V datapath, directly upstream of the 32x32 register file.
- Captures the instruction result from the ALU, load data, PC+4 or immediate source.
- Performs load byte/halfword extraction and sign/zero extension.
- Drives the register file write port (wrEn/wrAddr/wrData) for exactly one cycle per accepted instruction.

---
 rtl/riscv_wb_pkg.sv | 25 ++
 rtl/wb_load_align.sv | 54 +++++
 rtl/riscv_writeback_unit.sv | 172 +++++++++++++++++
 tb/tb_riscv_writeback_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_wb_pkg.sv
// Shared encodings for the RISC-V writeback stage: result sources, load funct3 codes and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package riscv_wb_pkg;

    // Result source select carried with each writeback request
    localparam logic [1:0] WB_SRC_ALU = 2'b00;
    localparam logic [1:0] WB_SRC_MEM = 2'b01;
    localparam logic [1:0] WB_SRC_PC4 = 2'b10;
    localparam logic [1:0] WB_SRC_IMM = 2'b11;

    // Load funct3 encodings (RV32I)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_load_align.sv
// Load lane extraction and sign/zero extension; flags illegal funct3 and misaligned offsets.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module wb_load_align
    import riscv_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_offset,
    input  logic [XLEN-1:0] i_word,
    output logic [XLEN-1:0] o_data,
    output logic            o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and halfword lanes out of the aligned word
    always_comb begin
        w_byte = i_word[7:0];
        case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    end

    // Extend the selected lane and classify the access
    always_comb begin
        o_data    = i_word;
        o_illegal = 1'b0;
        case (i_funct3)
            F3_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH: begin
                o_data    = {{(XLEN-16){w_half[15]}}, w_half};
                o_illegal = i_offset[0];
            end
            F3_LHU: begin
                o_data    = {{(XLEN-16){1'b0}}, w_half};
                o_illegal = i_offset[0];
            end
            F3_LW: begin
                o_data    = i_word;
                o_illegal = (i_offset != 2'd0);
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_writeback_unit.sv
// Final multicycle stage: selects ALU/MEM/PC+4/IMM result, aligns loads, drives one regfile write per request.
// Latency: non-MEM write 1 cycle after accept; MEM write 1 cycle after first memValid; accepts every 2nd cycle at best.
// Backpressure: issueReady high only in IDLE; requester holds issueValid. Optional macro WB_MEM_TIMEOUT_EN bounds WAIT_MEM.
module riscv_writeback_unit
    import riscv_wb_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issueValid,
    output logic            issueReady,
    input  logic [1:0]      issueSrc,
    input  logic [4:0]      issueRd,
    input  logic [2:0]      issueFunct3,
    input  logic [1:0]      issueOffset,
    input  logic [XLEN-1:0] aluResult,
    input  logic [XLEN-1:0] pcPlus4,
    input  logic [XLEN-1:0] immVal,
    input  logic            memValid,
    input  logic [XLEN-1:0] memRdata,
    output logic            wrEn,
    output logic [4:0]      wrAddr,
    output logic [XLEN-1:0] wrData,
    output logic            done,
    output logic            err
);

    wb_state_t       r_state;
    logic [4:0]      r_rd;
    logic [2:0]      r_funct3;
    logic [1:0]      r_offset;
    logic            r_wrEn;
    logic [4:0]      r_wrAddr;
    logic [XLEN-1:0] r_wrData;
    logic            r_done;
    logic            r_err;

    logic [XLEN-1:0] w_operand;
    logic [2:0]      w_al_funct3;
    logic [1:0]      w_al_offset;
    logic [XLEN-1:0] w_load_data;
    logic            w_load_illegal;
    logic            w_timeout;

    // Non-load operand chosen by the source code presented at issue
    always_comb begin
        w_operand = aluResult;
        case (issueSrc)
            WB_SRC_PC4: w_operand = pcPlus4;
            WB_SRC_IMM: w_operand = immVal;
            default:    w_operand = aluResult;
        endcase
    end

    // In IDLE the aligner screens the incoming request; afterwards it works on the latched load type
    always_comb begin
        w_al_funct3 = (r_state == IDLE) ? issueFunct3 : r_funct3;
        w_al_offset = (r_state == IDLE) ? issueOffset : r_offset;
    end

    wb_load_align #(
        .XLEN(XLEN)
    ) u_align (
        .i_funct3  (w_al_funct3),
        .i_offset  (w_al_offset),
        .i_word    (memRdata),
        .o_data    (w_load_data),
        .o_illegal (w_load_illegal)
    );

`ifdef WB_MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count WAIT_MEM cycles; held at zero outside WAIT_MEM so every entry starts fresh
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == WAIT_MEM) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Last permitted WAIT_MEM cycle; memValid in this same cycle still takes priority
    assign w_timeout = (r_state == WAIT_MEM) && (r_cnt == CNT_LAST);
`else
    // Without the timeout WAIT_MEM never expires; the expression is constant false
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // Control FSM with registered write-port, done and err outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rd     <= '0;
            r_funct3 <= '0;
            r_offset <= '0;
            r_wrEn   <= 1'b0;
            r_wrAddr <= '0;
            r_wrData <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_wrEn <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (issueValid) begin
                        r_rd     <= issueRd;
                        r_funct3 <= issueFunct3;
                        r_offset <= issueOffset;
                        if (issueSrc == WB_SRC_MEM) begin
                            if (w_load_illegal) begin
                                // Rejected at issue: retire with err, never wait on memory
                                r_err   <= 1'b1;
                                r_done  <= 1'b1;
                                r_state <= WRITE;
                            end else begin
                                r_state <= WAIT_MEM;
                            end
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= WRITE;
                            // x0 is hardwired zero: retire without touching the port
                            if (issueRd != 5'd0) begin
                                r_wrEn   <= 1'b1;
                                r_wrAddr <= issueRd;
                                r_wrData <= w_operand;
                            end
                        end
                    end
                end
                WAIT_MEM: begin
                    if (memValid) begin
                        r_done  <= 1'b1;
                        r_state <= WRITE;
                        if (r_rd != 5'd0) begin
                            r_wrEn   <= 1'b1;
                            r_wrAddr <= r_rd;
                            r_wrData <= w_load_data;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign issueReady = (r_state == IDLE);
    assign wrEn       = r_wrEn;
    assign wrAddr     = r_wrAddr;
    assign wrData     = r_wrData;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_riscv_writeback_unit.sv
// Directed bench for riscv_writeback_unit: ALU/PC4/IMM writes, load extraction, illegal loads, busy hold, reset.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: issueValid held through busy cycles to check non-acceptance.
module tb_riscv_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issueValid;
    logic        issueReady;
    logic [1:0]  issueSrc;
    logic [4:0]  issueRd;
    logic [2:0]  issueFunct3;
    logic [1:0]  issueOffset;
    logic [31:0] aluResult;
    logic [31:0] pcPlus4;
    logic [31:0] immVal;
    logic        memValid;
    logic [31:0] memRdata;
    logic        wrEn;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_writeback_unit #(
        .XLEN(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issueValid  (issueValid),
        .issueReady  (issueReady),
        .issueSrc    (issueSrc),
        .issueRd     (issueRd),
        .issueFunct3 (issueFunct3),
        .issueOffset (issueOffset),
        .aluResult   (aluResult),
        .pcPlus4     (pcPlus4),
        .immVal      (immVal),
        .memValid    (memValid),
        .memRdata    (memRdata),
        .wrEn        (wrEn),
        .wrAddr      (wrAddr),
        .wrData      (wrData),
        .done        (done),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Legal load: memValid is also high in the issue cycle (must be ignored), real data 3 cycles later
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] off,
                           input logic [4:0] rd, input logic [31:0] word, input logic [31:0] exp);
        issueValid  = 1'b1;
        issueSrc    = 2'b01;
        issueRd     = rd;
        issueFunct3 = f3;
        issueOffset = off;
        memValid    = 1'b1;
        memRdata    = ~word;
        tick();
        issueValid = 1'b0;
        memValid   = 1'b0;
        memRdata   = word;
        check({tag, "_issue_done"}, 32'(done), 32'd0);
        check({tag, "_issue_ready"}, 32'(issueReady), 32'd0);
        tick();
        tick();
        memValid = 1'b1;
        tick();
        memValid = 1'b0;
        check({tag, "_wren"}, 32'(wrEn), 32'd1);
        check({tag, "_addr"}, 32'(wrAddr), 32'(rd));
        check({tag, "_data"}, wrData, exp);
        check({tag, "_done"}, 32'(done), 32'd1);
        tick();
        check({tag, "_ready"}, 32'(issueReady), 32'd1);
    endtask

    // Illegal load: err+done next cycle, no write, stray memValid afterwards ignored
    task automatic do_illegal(input string tag, input logic [2:0] f3, input logic [1:0] off);
        issueValid  = 1'b1;
        issueSrc    = 2'b01;
        issueRd     = 5'd12;
        issueFunct3 = f3;
        issueOffset = off;
        memValid    = 1'b0;
        tick();
        issueValid = 1'b0;
        check({tag, "_err"}, 32'(err), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_wren"}, 32'(wrEn), 32'd0);
        memValid = 1'b1;
        tick();
        check({tag, "_err_clr"}, 32'(err), 32'd0);
        tick();
        memValid = 1'b0;
        check({tag, "_late_wren"}, 32'(wrEn), 32'd0);
        check({tag, "_late_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        issueValid  = 1'b0;
        issueSrc    = 2'b00;
        issueRd     = 5'd0;
        issueFunct3 = 3'd0;
        issueOffset = 2'd0;
        aluResult   = 32'd0;
        pcPlus4     = 32'd0;
        immVal      = 32'd0;
        memValid    = 1'b0;
        memRdata    = 32'd0;
        tick();
        tick();
        check("rst_wren",  32'(wrEn), 32'd0);
        check("rst_addr",  32'(wrAddr), 32'd0);
        check("rst_data",  wrData, 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_ready", 32'(issueReady), 32'd1);
        rst_n = 1'b1;
        tick();

        // ALU result, rd=5
        issueValid = 1'b1;
        issueSrc   = 2'b00;
        issueRd    = 5'd5;
        aluResult  = 32'h0000_1234;
        pcPlus4    = 32'h0000_0104;
        immVal     = 32'h0000_5000;
        tick();
        issueValid = 1'b0;
        aluResult  = 32'hDEAD_BEEF;
        check("alu_wren",  32'(wrEn), 32'd1);
        check("alu_addr",  32'(wrAddr), 32'd5);
        check("alu_data",  wrData, 32'h0000_1234);
        check("alu_done",  32'(done), 32'd1);
        check("alu_err",   32'(err), 32'd0);
        check("alu_busy",  32'(issueReady), 32'd0);
        tick();
        check("alu_wren_clr", 32'(wrEn), 32'd0);
        check("alu_done_clr", 32'(done), 32'd0);
        check("alu_ready",    32'(issueReady), 32'd1);
        check("alu_hold",     wrData, 32'h0000_1234);

        // PC+4 source, rd=7
        issueValid = 1'b1;
        issueSrc   = 2'b10;
        issueRd    = 5'd7;
        tick();
        issueValid = 1'b0;
        check("pc4_addr", 32'(wrAddr), 32'd7);
        check("pc4_data", wrData, 32'h0000_0104);
        tick();

        // Request held while busy: second one accepted only once ready returns
        issueValid = 1'b1;
        issueSrc   = 2'b00;
        issueRd    = 5'd3;
        aluResult  = 32'h0000_0033;
        tick();
        issueRd   = 5'd4;
        aluResult = 32'h0000_0044;
        check("hold_busy", 32'(issueReady), 32'd0);
        check("hold_addr1", 32'(wrAddr), 32'd3);
        tick();
        check("hold_ready", 32'(issueReady), 32'd1);
        check("hold_nowr",  32'(wrEn), 32'd0);
        tick();
        issueValid = 1'b0;
        check("hold_wren2", 32'(wrEn), 32'd1);
        check("hold_addr2", 32'(wrAddr), 32'd4);
        check("hold_data2", wrData, 32'h0000_0044);
        tick();

        // Load extraction
        do_load("lb",   3'b000, 2'd2, 5'd9,  32'h0080_0000, 32'hFFFF_FF80);
        do_load("lbu",  3'b100, 2'd2, 5'd9,  32'h0080_0000, 32'h0000_0080);
        do_load("lb3",  3'b000, 2'd3, 5'd14, 32'h7F00_0000, 32'h0000_007F);
        do_load("lh",   3'b001, 2'd2, 5'd15, 32'h8001_7FFF, 32'hFFFF_8001);
        do_load("lhu",  3'b101, 2'd0, 5'd16, 32'h8001_7FFF, 32'h0000_7FFF);
        do_load("lw",   3'b010, 2'd0, 5'd17, 32'h1234_5678, 32'h1234_5678);

        // Illegal / misaligned loads
        do_illegal("lw_mis",  3'b010, 2'd1);
        check("lw_mis_hold", 32'(wrAddr), 32'd17);
        do_illegal("f3_011",  3'b011, 2'd0);
        do_illegal("lh_mis",  3'b001, 2'd1);
        do_illegal("lhu_mis", 3'b101, 2'd3);
        do_illegal("f3_110",  3'b110, 2'd0);

        // rd=0 immediate: retires but never writes
        issueValid = 1'b1;
        issueSrc   = 2'b11;
        issueRd    = 5'd0;
        immVal     = 32'hABCD_E000;
        tick();
        issueValid = 1'b0;
        check("x0_done", 32'(done), 32'd1);
        check("x0_wren", 32'(wrEn), 32'd0);
        check("x0_hold", wrData, 32'h1234_5678);
        tick();
        check("x0_wren2", 32'(wrEn), 32'd0);

        // Reset while waiting on memory
        issueValid  = 1'b1;
        issueSrc    = 2'b01;
        issueRd     = 5'd10;
        issueFunct3 = 3'b010;
        issueOffset = 2'd0;
        tick();
        issueValid = 1'b0;
        tick();
        check("rmid_waiting", 32'(issueReady), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rmid_addr",  32'(wrAddr), 32'd0);
        check("rmid_data",  wrData, 32'd0);
        check("rmid_wren",  32'(wrEn), 32'd0);
        check("rmid_ready", 32'(issueReady), 32'd1);
        #2;
        rst_n    = 1'b1;
        memValid = 1'b1;
        memRdata = 32'hCAFE_F00D;
        tick();
        tick();
        memValid = 1'b0;
        check("rmid_nowr",  32'(wrEn), 32'd0);
        check("rmid_nodone", 32'(done), 32'd0);
        check("rmid_ready2", 32'(issueReady), 32'd1);

`ifdef WB_MEM_TIMEOUT_EN
        // No memValid: err after 4 WAIT_MEM cycles
        issueValid  = 1'b1;
        issueSrc    = 2'b01;
        issueRd     = 5'd11;
        issueFunct3 = 3'b010;
        issueOffset = 2'd0;
        tick();
        issueValid = 1'b0;
        tick();
        tick();
        tick();
        check("to_pending", 32'(err), 32'd0);
        tick();
        check("to_err",  32'(err), 32'd1);
        check("to_done", 32'(done), 32'd1);
        check("to_wren", 32'(wrEn), 32'd0);
        tick();
        check("to_ready", 32'(issueReady), 32'd1);
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
